// File: rtl/udma_hyper_rxfifo.sv
// RX elastic buffer between the hyperbus 16->32 width converter and the uDMA RX channel.
// First-word-fall-through FIFO with a per-transfer word counter that tags the final word and pulses done_o.
module udma_hyper_rxfifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TRANS_SIZE = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     start_i,
    input  logic [TRANS_SIZE-1:0]    cfg_nb_words_i,
    input  logic                     in_valid_i,
    input  logic [DATA_WIDTH-1:0]    in_data_i,
    output logic                     in_ready_o,
    output logic                     out_valid_o,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic                     out_last_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   elements_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]         PTR_ONE = 1;
    localparam logic [TRANS_SIZE-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                head;
    state_e                state_q, state_d;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [TRANS_SIZE-1:0] remaining;
    logic                  full, empty;
    logic                  push, pop, last_push;
    logic                  done_q, done_d;

    // Extra pointer MSB tells full from empty when the low bits coincide.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign push      = in_valid_i && in_ready_o;
    assign pop       = out_valid_o && out_ready_i;
    assign last_push = push && (remaining == CNT_ONE);
    assign head      = mem[rd_ptr[AW-1:0]];

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; clr_i overrides everything and cancels a pending done.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_nb_words_i != '0) state_d = ACTIVE;
                        else                      done_d  = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (last_push) state_d = DRAIN;
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, so out_ready_i never reaches in_ready_o.
    always_comb begin
        in_ready_o  = (state_q == ACTIVE) && !full;
        out_valid_o = !empty;
        out_data_o  = head.data;
        out_last_o  = !empty && head.last;
        busy_o      = (state_q != IDLE);
        done_o      = done_q;
        elements_o  = wr_ptr - rd_ptr;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
        end else if (clr_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (state_q == IDLE && start_i && cfg_nb_words_i != '0)
                remaining <= cfg_nb_words_i;
            else if (push)
                remaining <= remaining - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i) mem[wr_ptr[AW-1:0]] <= '{last: last_push, data: in_data_i};
    end

endmodule

// File: tb/tb_udma_hyper_rxfifo.sv
// Scoreboard bench for udma_hyper_rxfifo: accepted words are queued with their expected last tag,
// a negedge monitor compares every word the DUT hands to the uDMA side.
module tb_udma_hyper_rxfifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        start;
    logic [15:0] cfg_nb;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  elements;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    udma_hyper_rxfifo #(.DATA_WIDTH(32), .DEPTH(8), .TRANS_SIZE(16)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .start_i(start), .cfg_nb_words_i(cfg_nb),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready), .elements_o(elements), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on the output side pops one expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (done === 1'b1) done_seen++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h expected=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(mon_e[31:0]));
                    chk("sb_last", 64'(out_last), 64'(mon_e[32]));
                end
            end
        end
    end

    task automatic start_xfer(input logic [15:0] n);
        start  = 1'b1;
        cfg_nb = n;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                exp_q.push_back({last, d});
                ok = 1'b1;
            end else begin
                @(posedge clk);
            end
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1'b1;
        end
        if (!idle) chk(name, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; start = 1'b0; cfg_nb = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_last", 64'(out_last), 0);
        chk("rst_elements", 64'(elements), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: three words streamed through, one-cycle fall-through latency
        out_ready = 1'b1;
        start_xfer(16'd3);
        chk("t1_busy", 64'(busy), 1);
        push_word(32'hA000_000A, 1'b0);
        chk("t1_lat_valid", 64'(out_valid), 1);
        chk("t1_lat_data", 64'(out_data), 64'hA000_000A);
        push_word(32'hB000_000B, 1'b0);
        push_word(32'hC000_000C, 1'b1);
        chk("t1_lat_last", 64'(out_last), 1);
        wait_idle("t1_idle_timeout");
        done_exp = 1;
        chk("t1_done_count", 64'(done_seen), 64'(done_exp));
        chk("t1_busy_after", 64'(busy), 0);
        chk("t1_sb_empty", 64'(exp_q.size()), 0);

        // 2: fill to DEPTH with the consumer stalled
        out_ready = 1'b0;
        start_xfer(16'd10);
        for (int i = 0; i < 8; i++) push_word(32'h1000_0000 + 32'(i), 1'b0);
        chk("t2_full_ready", 64'(in_ready), 0);
        chk("t2_full_elems", 64'(elements), 8);
        chk("t2_full_valid", 64'(out_valid), 1);

        // 3: full + in_valid + pop in the same cycle: pop only
        in_valid  = 1'b1;
        in_data   = 32'h1000_0008;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_stall_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("t3_elems_after_pop", 64'(elements), 7);
        push_word(32'h1000_0008, 1'b0);
        push_word(32'h1000_0009, 1'b1);
        wait_idle("t2_idle_timeout");
        done_exp = 2;
        chk("t2_done_count", 64'(done_seen), 64'(done_exp));
        chk("t2_sb_empty", 64'(exp_q.size()), 0);

        // 4: zero-length transfer completes immediately
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        start_xfer(16'd0);
        chk("t4_busy", 64'(busy), 0);
        chk("t4_done_pulse", 64'(done), 1);
        chk("t4_in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        chk("t4_done_low", 64'(done), 0);
        chk("t4_elems", 64'(elements), 0);
        in_valid = 1'b0;
        done_exp = 3;
        chk("t4_done_count", 64'(done_seen), 64'(done_exp));

        // 5: flush mid-transfer, then a fresh transfer
        out_ready = 1'b0;
        start_xfer(16'd5);
        for (int i = 0; i < 3; i++) push_word(32'h5000_0000 + 32'(i), 1'b0);
        chk("t5_elems_before", 64'(elements), 3);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_q.delete();
        chk("t5_clr_elems", 64'(elements), 0);
        chk("t5_clr_busy", 64'(busy), 0);
        chk("t5_clr_valid", 64'(out_valid), 0);
        @(posedge clk); #1;
        chk("t5_clr_no_done", 64'(done_seen), 64'(done_exp));
        out_ready = 1'b1;
        start_xfer(16'd2);
        push_word(32'hE000_0000, 1'b0);
        push_word(32'hE000_0001, 1'b1);
        wait_idle("t5_idle_timeout");
        done_exp = 4;
        chk("t5_done_count", 64'(done_seen), 64'(done_exp));
        chk("t5_sb_empty", 64'(exp_q.size()), 0);

        // 6: asynchronous reset while draining
        out_ready = 1'b0;
        start_xfer(16'd2);
        push_word(32'hF000_0000, 1'b0);
        push_word(32'hF000_0001, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'hF000_0002;
        @(posedge clk); #1;
        chk("t6_drain_busy", 64'(busy), 1);
        chk("t6_drain_ready", 64'(in_ready), 0);
        chk("t6_drain_elems", 64'(elements), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 64'(in_ready), 0);
        chk("t6_rst_out_valid", 64'(out_valid), 0);
        chk("t6_rst_out_last", 64'(out_last), 0);
        chk("t6_rst_elements", 64'(elements), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_done", 64'(done), 0);
        exp_q.delete();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", 64'(done_seen), 64'(done_exp));
        chk("t6_idle_busy", 64'(busy), 0);
        chk("t6_idle_valid", 64'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
